barrier_damage_map: RTL and testbench

//  Parametrised barrier tracker: maps screen coords to (barrier, col, row) block, holds per-block health.

---
 rtl/barrier_damage_map_if.sv | 11 +
 rtl/barrier_damage_map.sv | 136 +++++++++++++
 tb/tb_barrier_damage_map.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/barrier_damage_map_if.sv
// barrier_damage_map_if: projectile hit request/response channel between collision logic and the barrier map
interface barrier_damage_map_if;
    logic        hit_valid;
    logic        hit_ready;
    logic [10:0] hit_x;
    logic [10:0] hit_y;
    logic        hit_done;
    logic        hit_absorbed;
    modport master (output hit_valid, hit_x, hit_y, input hit_ready, hit_done, hit_absorbed);
    modport slave (input hit_valid, hit_x, hit_y, output hit_ready, hit_done, hit_absorbed);
endinterface

// File: rtl/barrier_damage_map.sv
// barrier_damage_map: screen-to-block decode, per-block health, pixel query pipeline and hit/restore FSM
module barrier_damage_map #(
    parameter int NUM_BARR    = 4,
    parameter int BLK_COLS    = 4,
    parameter int BLK_ROWS    = 4,
    parameter int BLK_SZ      = 8,
    parameter int BARR_X0     = 100,
    parameter int BARR_PITCH  = 150,
    parameter int BARR_YSTART = 400,
    parameter int HP_BITS     = 2
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [10:0]                                     px_x,
    input  logic [10:0]                                     px_y,
    output logic                                            pix_in_barr,
    output logic [HP_BITS-1:0]                              pix_hp,
    barrier_damage_map_if.slave                             hit,
    input  logic                                            restore,
    output logic                                            restore_busy,
    output logic [$clog2(NUM_BARR*BLK_COLS*BLK_ROWS+1)-1:0] blocks_left
);
    localparam int NUM_BLKS = NUM_BARR * BLK_COLS * BLK_ROWS;
    localparam int IW = NUM_BLKS > 1 ? $clog2(NUM_BLKS) : 1;
    localparam int BW = $clog2(NUM_BLKS + 1);
    localparam int LSZ = $clog2(BLK_SZ);
    localparam logic [HP_BITS-1:0] MAX_HP = '1;

    typedef enum logic [1:0] {IDLE, DECODE, APPLY, SWEEP} state_t;

    state_t             state;
    logic [10:0]        hx, hy;
    logic               h_in;
    logic [IW-1:0]      h_idx, cnt, q_idx;
    logic               q_in;
    logic               restore_pend;
    logic [HP_BITS-1:0] hp [NUM_BLKS];
    logic [HP_BITS-1:0] h_hp;

    // Returns {in_range, idx}; scanning down lets the lowest-numbered barrier win any overlap.
    function automatic logic [IW:0] decode(input logic [10:0] x, input logic [10:0] y);
        logic [IW:0] r;
        logic [31:0] xl, xo, yo;
        r = '0;
        yo = {21'd0, y} - 32'(BARR_YSTART);
        for (int b = NUM_BARR - 1; b >= 0; b--) begin
            xl = 32'(BARR_X0 + b * BARR_PITCH);
            xo = {21'd0, x} - xl;
            if ({21'd0, x} >= xl && xo < 32'(BLK_COLS * BLK_SZ) &&
                {21'd0, y} >= 32'(BARR_YSTART) && yo < 32'(BLK_ROWS * BLK_SZ))
                r = {1'b1, IW'(32'(b * BLK_COLS * BLK_ROWS) + (yo >> LSZ) * 32'(BLK_COLS) + (xo >> LSZ))};
        end
        return r;
    endfunction

    assign hit.hit_ready = (state == IDLE) && !restore_pend && !restore;
    assign h_hp = hp[h_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_in        <= 1'b0;
            q_idx       <= '0;
            pix_in_barr <= 1'b0;
            pix_hp      <= '0;
        end else begin
            {q_in, q_idx} <= decode(px_x, px_y);
            pix_in_barr   <= q_in;
            pix_hp        <= q_in ? hp[q_idx] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            hx               <= '0;
            hy               <= '0;
            h_in             <= 1'b0;
            h_idx            <= '0;
            cnt              <= '0;
            restore_pend     <= 1'b0;
            restore_busy     <= 1'b0;
            hit.hit_done     <= 1'b0;
            hit.hit_absorbed <= 1'b0;
            blocks_left      <= BW'(NUM_BLKS);
            for (int i = 0; i < NUM_BLKS; i++) hp[i] <= MAX_HP;
        end else begin
            hit.hit_done     <= 1'b0;
            hit.hit_absorbed <= 1'b0;
            case (state)
                IDLE: begin
                    if (restore || restore_pend) begin
                        state        <= SWEEP;
                        cnt          <= '0;
                        restore_pend <= 1'b0;
                        restore_busy <= 1'b1;
                    end else if (hit.hit_valid) begin
                        hx    <= hit.hit_x;
                        hy    <= hit.hit_y;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    {h_in, h_idx} <= decode(hx, hy);
                    restore_pend  <= restore_pend | restore;
                    state         <= APPLY;
                end
                APPLY: begin
                    hit.hit_done <= 1'b1;
                    if (h_in && h_hp != '0) begin
                        hp[h_idx]        <= h_hp - 1'b1;
                        hit.hit_absorbed <= 1'b1;
                        if (h_hp == HP_BITS'(1)) blocks_left <= blocks_left - 1'b1;
                    end
                    if (restore_pend) begin
                        state        <= SWEEP;
                        cnt          <= '0;
                        restore_pend <= 1'b0;
                        restore_busy <= 1'b1;
                    end else begin
                        state        <= IDLE;
                        restore_pend <= restore;
                    end
                end
                default: begin
                    hp[cnt] <= MAX_HP;
                    cnt     <= cnt + 1'b1;
                    if (cnt == IW'(NUM_BLKS - 1)) begin
                        blocks_left  <= BW'(NUM_BLKS);
                        restore_busy <= 1'b0;
                        state        <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_barrier_damage_map.sv
// tb_barrier_damage_map: directed vector tables plus hand sequences for handshake, restore and reset corners
module tb_barrier_damage_map;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [10:0] px_x = '0, px_y = '0;
    logic        pix_in_barr;
    logic [1:0]  pix_hp;
    logic        restore = 1'b0;
    logic        restore_busy;
    logic [6:0]  blocks_left;
    int          total = 0, bad = 0;

    barrier_damage_map_if hif ();

    barrier_damage_map dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .px_x         (px_x),
        .px_y         (px_y),
        .pix_in_barr  (pix_in_barr),
        .pix_hp       (pix_hp),
        .hit          (hif),
        .restore      (restore),
        .restore_busy (restore_busy),
        .blocks_left  (blocks_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] x, y;
        logic        in_b;
        int          hp;
    } qvec_t;

    typedef struct {
        logic [10:0] x, y;
        logic        absorbed;
        logic        in_b;
        int          hp;
        int          bl;
    } hvec_t;

    qvec_t qv[8];
    hvec_t hv[8];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic qcheck(input logic [10:0] x, input logic [10:0] y, input logic in_b, input int hp, input string nm);
        px_x = x;
        px_y = y;
        repeat (3) step();
        check({nm, "_in"}, int'(pix_in_barr), int'(in_b));
        check({nm, "_hp"}, int'(pix_hp), hp);
    endtask

    // Present one request in IDLE, scramble the coords after acceptance, wait for hit_done.
    task automatic do_hit(input logic [10:0] x, input logic [10:0] y, output logic absorbed, output int lat);
        hif.hit_x = x;
        hif.hit_y = y;
        hif.hit_valid = 1'b1;
        step();
        hif.hit_valid = 1'b0;
        hif.hit_x = 11'($urandom);
        hif.hit_y = 11'($urandom);
        lat = 1;
        while (!hif.hit_done && lat < 10) begin
            step();
            lat++;
        end
        absorbed = hif.hit_absorbed;
        if (!hif.hit_done) check("hit_done_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic ab;
        int   lat, n, busy_cnt, rdy_bad;
        hif.hit_valid = 1'b0;
        hif.hit_x = '0;
        hif.hit_y = '0;
        qv[0] = '{11'd100, 11'd400, 1'b1, 3};
        qv[1] = '{11'd132, 11'd400, 1'b0, 0};
        qv[2] = '{11'd250, 11'd400, 1'b1, 3};
        qv[3] = '{11'd281, 11'd431, 1'b1, 3};
        qv[4] = '{11'd282, 11'd431, 1'b0, 0};
        qv[5] = '{11'd100, 11'd399, 1'b0, 0};
        qv[6] = '{11'd550, 11'd400, 1'b1, 3};
        qv[7] = '{11'd581, 11'd432, 1'b0, 0};
        hv[0] = '{11'd259, 11'd417, 1'b1, 1'b1, 2, 64};
        hv[1] = '{11'd259, 11'd417, 1'b1, 1'b1, 1, 64};
        hv[2] = '{11'd259, 11'd417, 1'b1, 1'b1, 0, 63};
        hv[3] = '{11'd259, 11'd417, 1'b0, 1'b1, 0, 63};
        hv[4] = '{11'd131, 11'd431, 1'b1, 1'b1, 2, 63};
        hv[5] = '{11'd132, 11'd400, 1'b0, 1'b0, 0, 63};
        hv[6] = '{11'd100, 11'd432, 1'b0, 1'b0, 0, 63};
        hv[7] = '{11'd99,  11'd410, 1'b0, 1'b0, 0, 63};

        #2 rst_n = 1'b0;
        #10 rst_n = 1'b1;
        check("rst_blocks_left", int'(blocks_left), 64);
        check("rst_pix_in", int'(pix_in_barr), 0);
        check("rst_pix_hp", int'(pix_hp), 0);
        check("rst_hit_done", int'(hif.hit_done), 0);
        check("rst_busy", int'(restore_busy), 0);
        check("rst_ready", int'(hif.hit_ready), 1);

        for (int i = 0; i < 8; i++)
            qcheck(qv[i].x, qv[i].y, qv[i].in_b, qv[i].hp, $sformatf("q%0d", i));

        for (int i = 0; i < 8; i++) begin
            do_hit(hv[i].x, hv[i].y, ab, lat);
            check($sformatf("hit%0d_abs", i), int'(ab), int'(hv[i].absorbed));
            check($sformatf("hit%0d_lat", i), lat, 3);
            qcheck(hv[i].x, hv[i].y, hv[i].in_b, hv[i].hp, $sformatf("hit%0d_q", i));
            check($sformatf("hit%0d_bl", i), int'(blocks_left), hv[i].bl);
        end

        // hit_valid held across DECODE with changing coords: only (400,400) may be applied
        hif.hit_x = 11'd400;
        hif.hit_y = 11'd400;
        hif.hit_valid = 1'b1;
        step();
        check("t4_rdy_decode", int'(hif.hit_ready), 0);
        check("t4_done_early1", int'(hif.hit_done), 0);
        hif.hit_x = 11'd100;
        hif.hit_y = 11'd400;
        step();
        check("t4_rdy_apply", int'(hif.hit_ready), 0);
        check("t4_done_early2", int'(hif.hit_done), 0);
        hif.hit_x = 11'd259;
        hif.hit_y = 11'd417;
        hif.hit_valid = 1'b0;
        step();
        check("t4_done", int'(hif.hit_done), 1);
        check("t4_abs", int'(hif.hit_absorbed), 1);
        step();
        check("t4_done_pulse", int'(hif.hit_done), 0);
        check("t4_rdy_after", int'(hif.hit_ready), 1);
        qcheck(11'd400, 11'd400, 1'b1, 2, "t4_target");
        qcheck(11'd100, 11'd400, 1'b1, 3, "t4_ignored");
        check("t4_bl", int'(blocks_left), 63);

        // restore one cycle after accept: the in-flight hit finishes, then the sweep runs
        hif.hit_x = 11'd401;
        hif.hit_y = 11'd401;
        hif.hit_valid = 1'b1;
        step();
        hif.hit_valid = 1'b0;
        restore = 1'b1;
        step();
        restore = 1'b0;
        n = 0;
        while (!hif.hit_done && n < 10) begin
            step();
            n++;
        end
        check("t5_done", int'(hif.hit_done), 1);
        check("t5_abs", int'(hif.hit_absorbed), 1);
        busy_cnt = 0;
        rdy_bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (restore_busy) begin
                busy_cnt++;
                if (hif.hit_ready) rdy_bad++;
            end else if (busy_cnt > 0) break;
            step();
        end
        check("t5_busy_cycles", busy_cnt, 64);
        check("t5_ready_in_sweep", rdy_bad, 0);
        check("t5_bl", int'(blocks_left), 64);
        qcheck(11'd401, 11'd401, 1'b1, 3, "t5_q0");
        qcheck(11'd259, 11'd417, 1'b1, 3, "t5_q1");
        qcheck(11'd131, 11'd431, 1'b1, 3, "t5_q2");

        // async reset in the middle of a sweep
        do_hit(11'd100, 11'd400, ab, lat);
        check("t6_pre_abs", int'(ab), 1);
        restore = 1'b1;
        step();
        restore = 1'b0;
        repeat (10) step();
        check("t6_busy_mid", int'(restore_busy), 1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_busy_rst", int'(restore_busy), 0);
        check("t6_bl_rst", int'(blocks_left), 64);
        check("t6_pix_in_rst", int'(pix_in_barr), 0);
        check("t6_pix_hp_rst", int'(pix_hp), 0);
        check("t6_ready_rst", int'(hif.hit_ready), 1);
        #3 rst_n = 1'b1;
        qcheck(11'd100, 11'd400, 1'b1, 3, "t6_sweep_q");

        // async reset while the FSM sits in APPLY
        hif.hit_x = 11'd400;
        hif.hit_y = 11'd400;
        hif.hit_valid = 1'b1;
        step();
        hif.hit_valid = 1'b0;
        step();
        #1 rst_n = 1'b0;
        #1;
        check("t6_apply_done", int'(hif.hit_done), 0);
        check("t6_apply_abs", int'(hif.hit_absorbed), 0);
        check("t6_apply_ready", int'(hif.hit_ready), 1);
        #3 rst_n = 1'b1;
        qcheck(11'd400, 11'd400, 1'b1, 3, "t6_apply_q");
        check("t6_apply_bl", int'(blocks_left), 64);
        step();
        check("t6_no_done", int'(hif.hit_done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
